bin2bcd_seq: RTL and testbench
==============================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL have parameter IN_W, default 16, binary input width.
REQ-002 SHALL have parameter DIGITS, default 4, number of BCD digits presented at the output.
REQ-003 SHALL have port CLK1, input, 1, system clock; all logic on its rising edge.
REQ-004 SHALL have port arst, input, 1, reset, synchronous, active-high.
REQ-005 SHALL have port start, input, 1, one-cycle request to convert bin.
REQ-006 SHALL have port bin, input, IN_W, unsigned binary value, sampled only on an accepted start.
REQ-007 SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-008 SHALL have port done, output, 1, one-cycle pulse when bcd/ovf update.
REQ-009 SHALL have port bcd, output, 4*DIGITS, packed BCD result with digit 0 in bits [3:0], held between conversions.
REQ-010 SHALL have port ovf, output, 1, high when the last converted value exceeded 10^DIGITS-1.

Function
REQ-011 SHALL implement an FSM with states IDLE, SHIFT and FINISH.
REQ-012 SHALL accept start only in IDLE: latch bin into a shift register, clear the internal BCD accumulator (DIGITS+1 digits), load iteration counter with IN_W, and go to SHIFT.
REQ-013 SHALL ignore start while in SHIFT or FINISH: no restart, no relatch.
REQ-014 SHALL, in each SHIFT cycle, add 3 to every accumulator digit >= 5, then shift {accumulator, shift register} left by one, then decrement the counter (double-dabble).
REQ-015 SHALL leave SHIFT for FINISH after exactly IN_W SHIFT cycles (counter reaches 0).
REQ-016 SHALL, in FINISH, update bcd/ovf, pulse done for exactly one cycle, and return to IDLE.
REQ-017 SHALL produce its result with fixed latency: start accepted at edge N gives done high during cycle N+IN_W+1 (cycle 17 after start for IN_W=16).
REQ-018 SHALL, if accumulator digit DIGITS is nonzero, drive bcd to all digits 9 and ovf=1; otherwise drive the low DIGITS digits and ovf=0.
REQ-019 SHALL assert busy in SHIFT and FINISH and deassert it in IDLE.
REQ-020 SHALL accept a start in the cycle immediately after done (back-to-back conversions, period IN_W+2).
REQ-021 SHALL keep bcd and ovf stable except on the done cycle.

Reset
REQ-022 SHALL, on arst at any clock edge including mid-conversion, go to IDLE, abandon the conversion, and clear busy, done, ovf, bcd, counter and internal registers.
REQ-023 SHALL ignore start in a cycle where arst is high.

Structure
REQ-024 SHALL take the FSM state encoding and the BCD constants (digit width 4, add-3 threshold 5, saturation digit 9) from a shared package.
REQ-025 SHALL use one sub-module bcd_add3, a 4-bit digit corrector, instantiated DIGITS+1 times.
REQ-026 SHALL register all outputs.
REQ-027 SHALL keep RTL within 120-400 lines.

Verification
REQ-028 SHALL verify: start with bin=1234 -> done at cycle 17, bcd=0x1234, ovf=0, busy high cycles 1-17.
REQ-029 SHALL verify: bin=0, then bin=9999 back-to-back -> bcd=0x0000 then bcd=0x9999, ovf=0 for both, second done 18 cycles after the first.
REQ-030 SHALL verify: bin=10000 -> bcd=0x9999, ovf=1; then bin=65535 -> bcd=0x9999, ovf=1; then bin=42 -> bcd=0x0042, ovf=0.
REQ-031 SHALL verify: start with bin=1234, second start with bin=5678 at cycle 5 -> single done at cycle 17 with bcd=0x1234.
REQ-032 SHALL verify: arst at cycle 8 of a conversion of bin=777 -> next cycle busy=0, bcd=0, ovf=0, done=0, and no done appears later.
REQ-033 SHALL verify: start and arst high in the same cycle -> stays IDLE, busy=0.

Source files
------------

// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding, BCD digit constants and the digit-correction rule.
package bin2bcd_seq_pkg;

    // Converter control states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_e;

    // Width of one packed BCD digit.
    localparam int BCD_DIGIT_W = 4;

    // Digits at or above this value overflow past 9 when doubled, so they get corrected first.
    localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESH = 4'd5;

    // Correction added to a digit before the shift.
    localparam logic [BCD_DIGIT_W-1:0] ADD3_VAL = 4'd3;

    // Digit used to fill the result when the value does not fit.
    localparam logic [BCD_DIGIT_W-1:0] SAT_DIGIT = 4'd9;

    // True when a digit must be corrected before the next doubling.
    function automatic logic digit_needs_fix(input logic [BCD_DIGIT_W-1:0] digit);
        return digit >= ADD3_THRESH;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Single-digit double-dabble corrector: adds 3 to a BCD digit of 5..9 so
// that the following left shift carries correctly into the next digit.
module bcd_add3
    import bin2bcd_seq_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    // Conditionally correct the digit; 5..9 maps to 8..12, which still fits 4 bits.
    always_comb begin
        // NOTE: assign a default before any condition so no path leaves digit_o unassigned (no latch).
        digit_o = digit_i;
        if (digit_needs_fix(digit_i)) begin
            digit_o = digit_i + ADD3_VAL;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock).
// A start in IDLE latches bin; IN_W SHIFT cycles later the FSM enters FINISH
// with bcd/ovf freshly registered and done high for that single cycle.
// The accumulator carries one spare digit so a value above 10^DIGITS-1 is
// detected and the output saturates to all nines with ovf set.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int DIGITS = 4
) (
    input  logic                          CLK1,
    input  logic                          arst,
    input  logic                          start,
    input  logic [IN_W-1:0]               bin,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                          ovf
);

    // Accumulator holds DIGITS result digits plus one overflow digit.
    localparam int ACC_DIGITS = DIGITS + 1;
    localparam int ACC_W      = BCD_DIGIT_W * ACC_DIGITS;
    localparam int OUT_W      = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W      = $clog2(IN_W + 1);

    // Control state.
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Datapath: binary shift register and BCD accumulator.
    logic [IN_W-1:0]  sr_q;
    logic [IN_W-1:0]  sr_d;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_corr;
    logic [ACC_W-1:0] acc_d;

    // Registered outputs and their next values.
    logic             busy_q;
    logic             done_q;
    logic [OUT_W-1:0] bcd_q;
    logic [OUT_W-1:0] bcd_d;
    logic             ovf_q;
    logic             ovf_d;

    // One corrector per accumulator digit, including the overflow digit.
    for (genvar g = 0; g < ACC_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i (acc_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_o (acc_corr[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // One double-dabble step: correct digits, shift the whole {acc, sr} left, count down.
    always_comb begin
        {acc_d, sr_d} = {acc_corr, sr_q} << 1;
        cnt_d         = cnt_q - CNT_W'(1);
    end

    // Result formatting from the post-shift accumulator: saturate when the spare digit is nonzero.
    always_comb begin
        ovf_d = |acc_d[ACC_W-1 -: BCD_DIGIT_W];
        bcd_d = acc_d[OUT_W-1:0];
        if (ovf_d) begin
            bcd_d = {DIGITS{SAT_DIGIT}};
        end
    end

    // Control FSM and all registered state; the final shift loads the outputs
    // so that bcd, ovf and done are all valid during the FINISH cycle.
    always_ff @(posedge CLK1) begin
        if (arst) begin
            // NOTE: the datapath registers are cleared too, so an abandoned conversion leaves nothing behind.
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register update based on pre-edge values.
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sr_q    <= bin;
                        acc_q   <= '0;
                        cnt_q   <= CNT_W'(IN_W);
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr_q  <= sr_d;
                    acc_q <= acc_d;
                    cnt_q <= cnt_d;
                    if (cnt_d == '0) begin
                        bcd_q   <= bcd_d;
                        ovf_q   <= ovf_d;
                        done_q  <= 1'b1;
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed scenarios plus randomized
// back-to-back conversions compared against a decimal reference model.
module tb_bin2bcd_seq;

    localparam int IN_W   = 16;
    localparam int DIGITS = 4;
    localparam int OUT_W  = 4 * DIGITS;
    localparam int LAT    = IN_W + 1;
    localparam int PERIOD = IN_W + 2;

    logic             CLK1 = 1'b0;
    logic             arst;
    logic             start;
    logic [IN_W-1:0]  bin;
    logic             busy;
    logic             done;
    logic [OUT_W-1:0] bcd;
    logic             ovf;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Outputs the design should currently be holding.
    logic [OUT_W-1:0] exp_bcd;
    logic             exp_ovf;

    bin2bcd_seq #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
        .CLK1  (CLK1),
        .arst  (arst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .ovf   (ovf)
    );

    always #5 CLK1 = ~CLK1;

    always @(posedge CLK1) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Decimal reference: {ovf, packed digits} for an unsigned value.
    function automatic logic [OUT_W:0] ref_conv(input longint unsigned v);
        longint unsigned  lim = 1;
        logic [OUT_W-1:0] r   = '0;
        for (int i = 0; i < DIGITS; i++) lim *= 10;
        if (v >= lim) begin
            for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'd9;
            return {1'b1, r};
        end
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return {1'b0, r};
    endfunction

    // Drive a one-cycle start; returns at the midpoint of the first cycle after the accepting edge.
    task automatic pulse_start(input logic [IN_W-1:0] v);
        @(negedge CLK1);
        check("idle_done", done, 1'b0);
        check("idle_busy", busy, 1'b0);
        start = 1'b1;
        bin   = v;
        @(negedge CLK1);
        start = 1'b0;
    endtask

    // Follow a conversion to its done cycle; optionally inject a start at cycle inj_k.
    task automatic run_conv(input logic [IN_W-1:0] v, input int inj_k,
                            input logic [IN_W-1:0] inj_v, output int done_cyc);
        logic [OUT_W:0] r;
        int k;
        r = ref_conv(v);
        k = 1;
        while (!done && k < LAT + 10) begin
            check("busy_during", busy, 1'b1);
            check("bcd_hold", bcd, exp_bcd);
            check("ovf_hold", ovf, exp_ovf);
            bin = IN_W'($urandom);
            if (k == inj_k) begin
                start = 1'b1;
                bin   = inj_v;
            end else begin
                start = 1'b0;
            end
            @(negedge CLK1);
            k++;
        end
        start    = 1'b0;
        done_cyc = cyc;
        check("latency", k, LAT);
        check("done_busy", busy, 1'b1);
        check("bcd", bcd, r[OUT_W-1:0]);
        check("ovf", ovf, r[OUT_W]);
        exp_bcd = r[OUT_W-1:0];
        exp_ovf = r[OUT_W];
    endtask

    // Count done pulses over n cycles; none are expected.
    task automatic watch_no_done(input int n);
        int pulses;
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK1);
            if (done) pulses++;
        end
        check("no_extra_done", pulses, 0);
    endtask

    initial begin
        int t0;
        int t1;
        int t2;
        logic [IN_W-1:0] v;

        arst    = 1'b1;
        start   = 1'b0;
        bin     = '0;
        exp_bcd = '0;
        exp_ovf = 1'b0;
        repeat (3) @(negedge CLK1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_bcd", bcd, 0);
        check("rst_ovf", ovf, 1'b0);
        arst = 1'b0;

        // Basic conversion and fixed latency.
        pulse_start(16'd1234);
        run_conv(16'd1234, 0, '0, t0);
        check("bcd_1234", bcd, 16'h1234);

        // Back-to-back: 0 then 9999.
        pulse_start(16'd0);
        run_conv(16'd0, 0, '0, t1);
        pulse_start(16'd9999);
        run_conv(16'd9999, 0, '0, t2);
        check("b2b_period", t2 - t1, PERIOD);
        check("bcd_9999", bcd, 16'h9999);

        // Overflow boundary and recovery.
        pulse_start(16'd10000);
        run_conv(16'd10000, 0, '0, t0);
        pulse_start(16'd65535);
        run_conv(16'd65535, 0, '0, t0);
        pulse_start(16'd42);
        run_conv(16'd42, 0, '0, t0);
        check("bcd_42", bcd, 16'h0042);

        // A start during SHIFT is ignored.
        pulse_start(16'd1234);
        run_conv(16'd1234, 5, 16'd5678, t0);
        watch_no_done(25);

        // Reset in the middle of a conversion.
        pulse_start(16'd777);
        repeat (7) @(negedge CLK1);
        arst = 1'b1;
        @(negedge CLK1);
        arst = 1'b0;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_bcd", bcd, 0);
        check("midrst_ovf", ovf, 1'b0);
        exp_bcd = '0;
        exp_ovf = 1'b0;
        watch_no_done(30);
        check("midrst_idle", busy, 1'b0);

        // Start together with reset is ignored.
        @(negedge CLK1);
        start = 1'b1;
        bin   = 16'd4321;
        arst  = 1'b1;
        @(negedge CLK1);
        start = 1'b0;
        arst  = 1'b0;
        check("rststart_busy", busy, 1'b0);
        @(negedge CLK1);
        check("rststart_busy2", busy, 1'b0);
        watch_no_done(20);
        check("rststart_bcd", bcd, 0);

        // Randomized back-to-back conversions, biased toward the overflow boundary.
        for (int i = 0; i < 24; i++) begin
            case (i % 3)
                0:       v = IN_W'($urandom_range(0, 65535));
                1:       v = IN_W'($urandom_range(9990, 10010));
                default: v = IN_W'($urandom_range(0, 9999));
            endcase
            pulse_start(v);
            run_conv(v, 0, '0, t0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
